// File: rtl/mismatch_monitor.sv
// Mismatch monitor: flags qualified A/B differences, accumulates them
// into a saturating count, and raises a sticky alarm at a threshold.
//
// Ports:
//   Clock    rising-edge clock
//   Reset_b  asynchronous active-low reset
//   A, B     WIDTH-bit operands compared bitwise
//   C        qualify term, active high
//   D        qualify term, active low
//   Clear    synchronous clear of Count, Alarm and State
//   F        registered qualified-mismatch flag (ignores Clear)
//   Count    CNT_W-bit saturating accumulator
//   Alarm    sticky flag, set once Count reaches THRESH
//   State    FSM state: 00 idle, 01 counting, 10 alarm
module mismatch_monitor #(
  parameter int WIDTH  = 4,
  parameter int CNT_W  = 8,
  parameter int MODE   = 0,
  parameter int THRESH = 16
) (
  input  logic             Clock,
  input  logic             Reset_b,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             C,
  input  logic             D,
  input  logic             Clear,
  output logic             F,
  output logic [CNT_W-1:0] Count,
  output logic             Alarm,
  output logic [1:0]       State
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    COUNT = 2'b01,
    ALARM = 2'b10
  } state_t;

  localparam logic [CNT_W-1:0] TH = CNT_W'(THRESH);

  logic             qual;
  logic [WIDTH-1:0] diff;
  logic             mis;
  logic [CNT_W:0]   pc;
  logic [CNT_W:0]   inc;
  logic [CNT_W:0]   sum;
  logic [CNT_W-1:0] cnt_d;
  logic             hit;

  logic             f_q;
  logic [CNT_W-1:0] cnt_q;
  logic             alarm_q;
  state_t           state_q;

  assign qual = C | ~D;
  assign diff = A ^ B;
  assign mis  = qual & (|diff);

  always_comb begin
    pc = '0;
    for (int i = 0; i < WIDTH; i++) begin
      pc = pc + {{CNT_W{1'b0}}, diff[i]};
    end
  end

  always_comb begin
    inc = '0;
    if (MODE == 0) begin
      inc = {{CNT_W{1'b0}}, mis};
    end else if (qual) begin
      inc = pc;
    end
  end

  // Sum carries one extra bit so saturation can see the overflow.
  assign sum   = {1'b0, cnt_q} + inc;
  assign cnt_d = sum[CNT_W] ? '1 : sum[CNT_W-1:0];
  assign hit   = (cnt_d >= TH);

  always_ff @(posedge Clock or negedge Reset_b) begin
    if (!Reset_b) begin
      f_q     <= 1'b0;
      cnt_q   <= '0;
      alarm_q <= 1'b0;
      state_q <= IDLE;
    end else begin
      f_q <= mis;
      if (Clear) begin
        cnt_q   <= '0;
        alarm_q <= 1'b0;
        state_q <= IDLE;
      end else if (inc != '0) begin
        cnt_q <= cnt_d;
        if (hit) begin
          alarm_q <= 1'b1;
        end
        case (state_q)
          ALARM:   state_q <= ALARM;
          COUNT:   state_q <= hit ? ALARM : COUNT;
          // IDLE, and the unused 2'b11 encoding, behave as idle.
          default: state_q <= hit ? ALARM : COUNT;
        endcase
      end
    end
  end

  assign F     = f_q;
  assign Count = cnt_q;
  assign Alarm = alarm_q;
  assign State = state_q;

endmodule
